// File: rtl/spi_rx_deser.sv
// rtl/spi_rx_deser.sv - SPI slave receive deserializer with sclk oversampling and valid/ready output
// All logic runs on clk. cs/sclk/mosi are synchronized, and the edge events are registered before the frame FSM.
module spi_rx_deser #(
    parameter int W    = 12,
    parameter int LEAD = 1,
    parameter int TAIL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cs_i,
    input  logic         sclk_i,
    input  logic         mosi_i,
    output logic [W-1:0] dout_o,
    output logic         dout_valid_o,
    input  logic         dout_ready_i,
    output logic         frame_err_o,
    output logic         overrun_o
);
    localparam int CW = $clog2(W + LEAD + TAIL + 1);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_TAIL} state_t;

    logic [2:0]    cs_q, sclk_q, mosi_q;
    logic          cs_fall_q, cs_rise_q, fall_q;
    logic [1:0]    settle_q;
    logic          armed_q;
    state_t        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bad_q, bad_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [W-1:0]  dout_q;
    logic          dout_valid_q, frame_err_q, overrun_q;
    logic          good_frame;

    // Arming waits until the synchronizers hold real pin values and cs has been seen high,
    // so a frame already in progress at reset release is never picked up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q      <= 3'b111;
            sclk_q    <= 3'b000;
            mosi_q    <= 3'b000;
            cs_fall_q <= 1'b0;
            cs_rise_q <= 1'b0;
            fall_q    <= 1'b0;
            settle_q  <= 2'd0;
            armed_q   <= 1'b0;
        end else begin
            cs_q      <= {cs_q[1:0], cs_i};
            sclk_q    <= {sclk_q[1:0], sclk_i};
            mosi_q    <= {mosi_q[1:0], mosi_i};
            cs_fall_q <= cs_q[2] & ~cs_q[1] & armed_q;
            cs_rise_q <= ~cs_q[2] & cs_q[1];
            fall_q    <= sclk_q[2] & ~sclk_q[1];
            if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
            if (settle_q == 2'd3 && cs_q[1]) armed_q <= 1'b1;
        end
    end

    // Effect of this cycle's sclk fall; a simultaneous cs_rise is judged on these values.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        shreg_d = shreg_q;
        if (fall_q) begin
            case (st_q)
                S_LEAD: begin
                    if (cnt_q == CW'(LEAD - 1)) begin
                        st_d  = S_SHIFT;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_SHIFT: begin
                    shreg_d[cnt_q] = mosi_q[2];
                    if (cnt_q == CW'(W - 1)) begin
                        st_d  = S_TAIL;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_TAIL: begin
                    if (cnt_q == CW'(TAIL)) bad_d = 1'b1;
                    else                    cnt_d = cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign good_frame = (st_d == S_TAIL) && (cnt_d == CW'(TAIL)) && !bad_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q         <= S_IDLE;
            cnt_q        <= '0;
            bad_q        <= 1'b0;
            shreg_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (dout_valid_q && dout_ready_i) dout_valid_q <= 1'b0;
            if (st_q == S_IDLE) begin
                if (cs_fall_q) begin
                    st_q    <= S_LEAD;
                    cnt_q   <= '0;
                    bad_q   <= 1'b0;
                    shreg_q <= '0;
                end
            end else if (cs_rise_q) begin
                st_q    <= S_IDLE;
                cnt_q   <= '0;
                bad_q   <= bad_d;
                shreg_q <= shreg_d;
                if (!good_frame) begin
                    frame_err_q <= 1'b1;
                end else if (!dout_valid_q || dout_ready_i) begin
                    dout_q       <= shreg_d;
                    dout_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else begin
                st_q    <= st_d;
                cnt_q   <= cnt_d;
                bad_q   <= bad_d;
                shreg_q <= shreg_d;
            end
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign frame_err_o  = frame_err_q;
    assign overrun_o    = overrun_q;
endmodule

// File: tb/tb_spi_rx_deser.sv
// tb/tb_spi_rx_deser.sv - directed self-checking bench for spi_rx_deser
module tb_spi_rx_deser;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_i = 1'b1;
    logic        sclk_i = 1'b0;
    logic        mosi_i = 1'b0;
    logic        dout_ready_i = 1'b0;
    logic [11:0] dout_o;
    logic        dout_valid_o, frame_err_o, overrun_o;

    int checks = 0;
    int failures = 0;

    int          vld_rises = 0, vld_hi = 0, fe_cnt = 0, ov_cnt = 0;
    logic [11:0] last_dout = '0;
    logic        prev_vld = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0;
    logic        wide_pulse = 1'b0, both_pulse = 1'b0;
    int          v0, h0, f0, o0;

    spi_rx_deser #(.W(12), .LEAD(1), .TAIL(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cs_i         (cs_i),
        .sclk_i       (sclk_i),
        .mosi_i       (mosi_i),
        .dout_o       (dout_o),
        .dout_valid_o (dout_valid_o),
        .dout_ready_i (dout_ready_i),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        prev_vld <= dout_valid_o;
        prev_fe  <= frame_err_o;
        prev_ov  <= overrun_o;
        if (dout_valid_o && !prev_vld) begin
            vld_rises <= vld_rises + 1;
            last_dout <= dout_o;
        end
        if (dout_valid_o) vld_hi <= vld_hi + 1;
        if (frame_err_o) fe_cnt <= fe_cnt + 1;
        if (overrun_o) ov_cnt <= ov_cnt + 1;
        if ((frame_err_o && prev_fe) || (overrun_o && prev_ov)) wide_pulse <= 1'b1;
        if (frame_err_o && overrun_o) both_pulse <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic sclk_cycle(input logic b);
        sclk_i = 1'b1;
        mosi_i = b;
        wait_clk(11);
        sclk_i = 1'b0;
        wait_clk(11);
    endtask

    // Leaves cs high at posedge+2 so the caller can time the response.
    task automatic send(input logic [11:0] d, input int nl, input int nd, input int nt);
        cs_i = 1'b0;
        wait_clk(11);
        for (int i = 0; i < nl; i++) sclk_cycle(1'b0);
        for (int i = 0; i < nd; i++) sclk_cycle(d[i]);
        for (int i = 0; i < nt; i++) sclk_cycle(1'b0);
        wait_clk(5);
        cs_i = 1'b1;
    endtask

    task automatic snap();
        v0 = vld_rises; h0 = vld_hi; f0 = fe_cnt; o0 = ov_cnt;
    endtask

    initial begin
        wait_clk(3);
        check("rst_dout", 32'(dout_o), 32'h0);
        check("rst_valid", 32'(dout_valid_o), 32'h0);
        check("rst_ferr", 32'(frame_err_o), 32'h0);
        check("rst_ovr", 32'(overrun_o), 32'h0);
        rst_n = 1'b1;
        wait_clk(6);

        // Nominal, including latency to the 4th edge after cs rises
        dout_ready_i = 1'b1;
        snap();
        send(12'hA5C, 1, 12, 1);
        repeat (3) @(posedge clk);
        #1 check("nom_valid_e3", 32'(dout_valid_o), 32'h0);
        @(posedge clk);
        #1 check("nom_valid_e4", 32'(dout_valid_o), 32'h1);
        check("nom_dout_e4", 32'(dout_o), 32'hA5C);
        wait_clk(8);
        check("nom_rises", 32'(vld_rises - v0), 32'h1);
        check("nom_width", 32'(vld_hi - h0), 32'h1);
        check("nom_last", 32'(last_dout), 32'hA5C);
        check("nom_ferr", 32'(fe_cnt - f0), 32'h0);

        // Hold with ready low, then a one-cycle ready
        dout_ready_i = 1'b0;
        send(12'h123, 1, 12, 1);
        wait_clk(10);
        check("hold_valid", 32'(dout_valid_o), 32'h1);
        check("hold_dout", 32'(dout_o), 32'h123);
        wait_clk(5);
        check("hold_valid2", 32'(dout_valid_o), 32'h1);
        dout_ready_i = 1'b1;
        @(posedge clk);
        #1 check("hold_consumed", 32'(dout_valid_o), 32'h0);
        #1 dout_ready_i = 1'b0;
        wait_clk(2);

        // Short frame then a good 0xFFF frame
        dout_ready_i = 1'b1;
        snap();
        send(12'h03F, 1, 6, 0);
        wait_clk(10);
        check("short_ferr", 32'(fe_cnt - f0), 32'h1);
        check("short_rises", 32'(vld_rises - v0), 32'h0);
        check("short_valid", 32'(dout_valid_o), 32'h0);
        snap();
        send(12'hFFF, 1, 12, 1);
        wait_clk(10);
        check("fff_rises", 32'(vld_rises - v0), 32'h1);
        check("fff_last", 32'(last_dout), 32'hFFF);
        check("fff_ferr", 32'(fe_cnt - f0), 32'h0);

        // Long frame: 15 falls
        snap();
        send(12'h5A5, 1, 12, 2);
        wait_clk(10);
        check("long_ferr", 32'(fe_cnt - f0), 32'h1);
        check("long_rises", 32'(vld_rises - v0), 32'h0);

        // Overrun
        dout_ready_i = 1'b0;
        snap();
        send(12'h001, 1, 12, 1);
        wait_clk(10);
        check("ovr_first_dout", 32'(dout_o), 32'h001);
        send(12'h002, 1, 12, 1);
        wait_clk(10);
        check("ovr_pulse", 32'(ov_cnt - o0), 32'h1);
        check("ovr_dout", 32'(dout_o), 32'h001);
        check("ovr_valid", 32'(dout_valid_o), 32'h1);
        check("ovr_ferr", 32'(fe_cnt - f0), 32'h0);
        dout_ready_i = 1'b1;
        wait_clk(2);
        check("ovr_drained", 32'(dout_valid_o), 32'h0);

        // Reset mid-frame, released with cs still low
        snap();
        cs_i = 1'b0;
        wait_clk(11);
        sclk_cycle(1'b0);
        for (int i = 0; i < 6; i++) sclk_cycle(1'b1);
        rst_n = 1'b0;
        wait_clk(2);
        check("mid_rst_dout", 32'(dout_o), 32'h0);
        check("mid_rst_valid", 32'(dout_valid_o), 32'h0);
        rst_n = 1'b1;
        for (int i = 6; i < 12; i++) sclk_cycle(1'b1);
        sclk_cycle(1'b0);
        wait_clk(5);
        cs_i = 1'b1;
        wait_clk(10);
        check("mid_rises", 32'(vld_rises - v0), 32'h0);
        check("mid_ferr", 32'(fe_cnt - f0), 32'h0);
        snap();
        send(12'h800, 1, 12, 1);
        wait_clk(10);
        check("after_rises", 32'(vld_rises - v0), 32'h1);
        check("after_last", 32'(last_dout), 32'h800);

        check("pulse_width", 32'(wide_pulse), 32'h0);
        check("pulse_exclusive", 32'(both_pulse), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_rx_deser.md
# spi_rx_deser

SPI receive deserializer on the slave side of the 12-bit SPI link: consumes `cs`, `sclk`, `mosi` from the SPI master transmitter and returns a parallel word on the system clock. It samples all three lines with synchronizers and oversamples `sclk`, so no logic runs in the `sclk` domain. It checks frame length and hands each accepted word to downstream logic through a valid/ready holding register.

## Interface
- `W`, 12: data bits per frame, transmitted LSB first.
- `LEAD`, 1: `sclk` falling edges after `cs` falls and before bit 0; these are discarded.
- `TAIL`, 1: `sclk` falling edges after bit W-1 and before `cs` rises; these are discarded.

Ports, clock and reset first:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cs`  in  1  chip select from master, active-low, asynchronous to `clk`.
- `sclk`  in  1  serial clock from master, asynchronous to `clk`.
- `mosi`  in  1  serial data; master updates it on `sclk` rise.
- `dout`  out  W  received word.
- `dout_valid`  out  1  `dout` holds an unconsumed word.
- `dout_ready`  in  1  consumer accepts `dout` this cycle.
- `frame_err`  out  1  one-cycle pulse: frame had the wrong edge count.
- `overrun`  out  1  one-cycle pulse: good frame dropped because `dout_valid` was still high.

## Operation
- **Synchronizers:** `cs`, `sclk`, `mosi` each pass through 2 flops, then a third flop for edge detection.
  - Reset value: `cs` stages 1, `sclk` stages 0, `mosi` stages 0.
- **Derived events** (all from synchronized values):
  - `fall` = sclk 1→0.
  - `cs_fall` = cs 1→0.
  - `cs_rise` = cs 0→1.
- **Data capture:** bits are sampled on `fall`, which is mid-bit relative to the master's `sclk` rise update. The synchronized `mosi` is used.
- **FSM states:** IDLE, LEAD, SHIFT, TAIL, plus a sticky `bad` flag.
  - IDLE: on `cs_fall`, go to LEAD and clear the edge counter, the shift register and `bad`.
  - LEAD: count `fall`; after LEAD falls, go to SHIFT.
  - SHIFT: on each `fall`, write `mosi` into `shreg[bitcnt]` and increment `bitcnt`; after W falls, go to TAIL.
  - TAIL: count `fall`. A fall beyond TAIL sets `bad`; the counter saturates.
  - `cs_rise` in any non-IDLE state: go to IDLE and evaluate the frame.
    - Good frame: state was TAIL with exactly TAIL falls and `bad` = 0. Deliver it.
    - Otherwise: pulse `frame_err` and discard the word.
  - `cs_rise` in IDLE is ignored. `fall` in IDLE is ignored.
- **Delivery:**
  - If `dout_valid` = 0 (or `dout_ready` = 1 in the same cycle): `dout` ← `shreg`, `dout_valid` ← 1.
  - Else: pulse `overrun`; `dout`/`dout_valid` keep the old word.
- **Handshake:** `dout_valid` and `ready` both high at a clock edge means the word is consumed. `dout_valid` falls unless a new word loads at that same edge. `dout` is stable while `dout_valid` is high.
- **Simultaneous events:** if `cs_rise` and `fall` are in the same cycle, `fall` is processed first, then the frame is evaluated.
- **Reset values:** `rst_n` low at any time, including mid-frame, gives:
  - `dout` = 0, `dout_valid` = 0, `frame_err` = 0, `overrun` = 0.
  - FSM in IDLE, counters 0.
  - The partial frame is lost.
  - After release, the first event acted on is the next `cs_fall`. If `cs` is already low at release, that frame is ignored.

## Timing
- Input constraint: `sclk` high and low phases, and the `cs` setup before the first `sclk` rise, are each ≥ 4 `clk` periods. The master's default divider gives 11.
- Latency from pin to internal event: the event registers on the 3rd `clk` rising edge at or after the pin transition.
- `dout_valid` rises, or `frame_err`/`overrun` pulse, on the 4th `clk` edge after the `cs` pin rises.
- `frame_err` and `overrun` are exactly 1 cycle wide. They never assert in the same cycle as each other.
- Back-to-back frames need ≥ 2 `clk` cycles of `cs` high. A `cs_fall` is accepted in the cycle immediately after the IDLE return.

## Test plan
- **Nominal:** master sends 0xA5C (LSB first; 1 lead, 12 data, 1 tail fall), `dout_ready` = 1 → `dout_valid` pulses 1 cycle with `dout` = 0xA5C; no `frame_err`.
- **Hold:** frame 0x123 with `dout_ready` = 0 → `dout_valid` stays high and `dout` = 0x123. Raising `ready` for 1 cycle → `dout_valid` drops on the next edge.
- **Short frame:** `cs` rises after 6 data bits → `frame_err` 1-cycle pulse; `dout_valid` stays 0. The following nominal 0xFFF frame → `dout` = 0xFFF.
- **Long frame:** 15 falls inside `cs` low → `frame_err`; no delivery.
- **Overrun:** frames 0x001 then 0x002 with `ready` = 0 → `overrun` pulses at the second frame's end; `dout` stays 0x001.
- **Reset mid-frame:** assert `rst_n` low after bit 5 and release with `cs` still low → no output for that frame. The next full frame 0x800 → `dout` = 0x800.
